// File: rtl/cpu6_bus_interface_pkg.sv
// Shared CPU6 bus definitions: FSM state encoding, default strobe timeout and
// the read-data value returned when an access times out.
package cpu6_bus_interface_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } bus_state_e;

    localparam int         DEFAULT_TIMEOUT_CYCLES = 16;
    localparam logic [7:0] RDATA_ERROR            = 8'hFF;

endpackage

// File: rtl/cpu6_bus_interface.sv
// CPU6 external bus interface: turns a single CPU access request into an
// IDLE/SETUP/STROBE/HOLD bus cycle with wait states, ready extension and timeout.
module cpu6_bus_interface
    import cpu6_bus_interface_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        addr_load,
    input  logic [15:0] addr_in,
    input  logic        addr_inc,
    input  logic [7:0]  wdata,
    input  logic [1:0]  wait_states,
    output logic        busy,
    output logic        done,
    output logic        bus_error,
    output logic [7:0]  rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data_out,
    output logic        mem_data_oe,
    input  logic [7:0]  mem_data_in,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic        mem_ready,
    output bus_state_e  state_dbg
);

    // Handshake: req is a request-valid that is only accepted in IDLE (busy=0);
    // one accepted req always yields exactly one done pulse unless reset
    // intervenes. There is no ready/backpressure on req: while busy it is dropped.
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    bus_state_e    state;
    logic [15:0]   mar;
    logic          we_q;
    logic          inc_q;
    logic [1:0]    ws_q;
    logic [CW-1:0] strobe_cnt;
    logic          min_met;
    logic          timeout_hit;

    // strobe_cnt holds the number of STROBE cycles already completed before
    // the current one, so the edge ending this cycle completes strobe_cnt+1.
    assign min_met     = strobe_cnt >= CW'(ws_q);
    assign timeout_hit = strobe_cnt == CW'(TIMEOUT_CYCLES - 1);

    assign mem_addr  = mar;
    assign state_dbg = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            mar          <= 16'h0000;
            rdata        <= 8'h00;
            mem_data_out <= 8'h00;
            we_q         <= 1'b0;
            inc_q        <= 1'b0;
            ws_q         <= 2'd0;
            strobe_cnt   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            bus_error    <= 1'b0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_data_oe  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (addr_load) begin
                        mar <= addr_in;
                    end
                    if (req) begin
                        state        <= ST_SETUP;
                        we_q         <= we;
                        inc_q        <= addr_inc;
                        mem_data_out <= wdata;
                        ws_q         <= wait_states;
                        strobe_cnt   <= '0;
                        busy         <= 1'b1;
                        mem_data_oe  <= we;
                    end
                end
                ST_SETUP: begin
                    state  <= ST_STROBE;
                    mem_rd <= ~we_q;
                    mem_wr <= we_q;
                end
                ST_STROBE: begin
                    // A ready device wins over timeout on the final allowed cycle.
                    if (min_met && mem_ready) begin
                        state  <= ST_HOLD;
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        done   <= 1'b1;
                        if (!we_q) begin
                            rdata <= mem_data_in;
                        end
                    end else if (timeout_hit) begin
                        state     <= ST_HOLD;
                        mem_rd    <= 1'b0;
                        mem_wr    <= 1'b0;
                        done      <= 1'b1;
                        bus_error <= 1'b1;
                        if (!we_q) begin
                            rdata <= RDATA_ERROR;
                        end
                    end else begin
                        strobe_cnt <= strobe_cnt + CW'(1);
                    end
                end
                ST_HOLD: begin
                    state       <= ST_IDLE;
                    done        <= 1'b0;
                    bus_error   <= 1'b0;
                    busy        <= 1'b0;
                    mem_data_oe <= 1'b0;
                    if (inc_q) begin
                        mar <= mar + 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu6_bus_interface.sv
// Directed bench for cpu6_bus_interface: read/write latency, wait states,
// address wrap, timeout, reset abort and ignored inputs while busy.
module tb_cpu6_bus_interface;
    import cpu6_bus_interface_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic        addr_load;
    logic [15:0] addr_in;
    logic        addr_inc;
    logic [7:0]  wdata;
    logic [1:0]  wait_states;
    logic        busy;
    logic        done;
    logic        bus_error;
    logic [7:0]  rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data_out;
    logic        mem_data_oe;
    logic [7:0]  mem_data_in;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_ready;
    bus_state_e  state_dbg;

    int checks   = 0;
    int failures = 0;

    int done_cyc, rd_cyc, wr_cyc, oe_cyc, both_cyc, err_at_done;
    int ready_low;
    bit toggle_busy;
    int idle_done, idle_busy;

    cpu6_bus_interface #(.TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset), .req(req), .we(we),
        .addr_load(addr_load), .addr_in(addr_in), .addr_inc(addr_inc),
        .wdata(wdata), .wait_states(wait_states), .busy(busy), .done(done),
        .bus_error(bus_error), .rdata(rdata), .mem_addr(mem_addr),
        .mem_data_out(mem_data_out), .mem_data_oe(mem_data_oe),
        .mem_data_in(mem_data_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_ready(mem_ready), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge (edge k), then return in cycle k+1.
    task automatic launch(input logic ld, input logic [15:0] addr, input logic w,
                          input logic inc, input logic [7:0] wd, input logic [1:0] ws);
        addr_load   = ld;
        addr_in     = addr;
        req         = 1'b1;
        we          = w;
        addr_inc    = inc;
        wdata       = wd;
        wait_states = ws;
        tick;
        req       = 1'b0;
        addr_load = 1'b0;
    endtask

    // Run from cycle k+1 until done; done_cyc is the cycle offset from k.
    task automatic run_access;
        int n       = 1;
        int strobes = 0;
        bit got     = 1'b0;
        done_cyc = -1; rd_cyc = 0; wr_cyc = 0; oe_cyc = 0; both_cyc = 0; err_at_done = 0;
        while (!got && n <= 40) begin
            if (mem_rd && mem_wr) both_cyc++;
            if (mem_rd) rd_cyc++;
            if (mem_wr) wr_cyc++;
            if (mem_data_oe) oe_cyc++;
            if (done) begin
                got         = 1'b1;
                done_cyc    = n;
                err_at_done = int'(bus_error);
            end else begin
                if (mem_rd || mem_wr) begin
                    mem_ready = (strobes >= ready_low);
                    strobes++;
                end else begin
                    mem_ready = 1'b0;
                end
                if (toggle_busy) begin
                    req       = n[0];
                    addr_load = 1'b1;
                    addr_in   = 16'hDEAD;
                end
                tick;
                n++;
            end
        end
        req       = 1'b0;
        addr_load = 1'b0;
        check("done_within_bound", 32'(got), 32'd1);
    endtask

    initial begin
        reset = 1'b0; req = 1'b0; we = 1'b0; addr_load = 1'b0; addr_in = 16'h0;
        addr_inc = 1'b0; wdata = 8'h0; wait_states = 2'd0; mem_data_in = 8'h0;
        mem_ready = 1'b0; ready_low = 0; toggle_busy = 1'b0;
        tick; tick; tick;

        // Reset state
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_bus_error", 32'(bus_error), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_mem_data_out", 32'(mem_data_out), 0);
        check("rst_strobes", 32'({mem_rd, mem_wr, mem_data_oe}), 0);
        reset = 1'b1;
        tick;

        // Read, zero wait, load address together with req
        mem_data_in = 8'hA5; ready_low = 0;
        launch(1'b1, 16'h1234, 1'b0, 1'b0, 8'h00, 2'd0);
        check("rd0_setup_busy", 32'(busy), 1);
        check("rd0_setup_addr", 32'(mem_addr), 32'h1234);
        check("rd0_setup_nostrobe", 32'({mem_rd, mem_wr}), 0);
        run_access;
        check("rd0_done_cycle", 32'(done_cyc), 3);
        check("rd0_rd_cycles", 32'(rd_cyc), 1);
        check("rd0_wr_cycles", 32'(wr_cyc), 0);
        check("rd0_oe_cycles", 32'(oe_cyc), 0);
        check("rd0_no_error", 32'(err_at_done), 0);
        check("rd0_rdata", 32'(rdata), 32'hA5);
        tick;
        check("rd0_idle_busy", 32'(busy), 0);
        check("rd0_idle_done", 32'(done), 0);
        check("rd0_mar_stays", 32'(mem_addr), 32'h1234);

        // Back-to-back: req accepted at k+4, write with 2 wait states, ready low 4 strobes
        mem_data_in = 8'h11; ready_low = 4;
        launch(1'b1, 16'h0100, 1'b1, 1'b1, 8'h3C, 2'd2);
        check("wr_setup_oe", 32'(mem_data_oe), 1);
        check("wr_data_out", 32'(mem_data_out), 32'h3C);
        run_access;
        check("wr_done_cycle", 32'(done_cyc), 7);
        check("wr_wr_cycles", 32'(wr_cyc), 5);
        check("wr_rd_cycles", 32'(rd_cyc), 0);
        check("wr_oe_cycles", 32'(oe_cyc), 7);
        check("wr_no_overlap", 32'(both_cyc), 0);
        check("wr_no_error", 32'(err_at_done), 0);
        check("wr_rdata_held", 32'(rdata), 32'hA5);
        tick;
        check("wr_oe_idle", 32'(mem_data_oe), 0);
        check("wr_mar_inc", 32'(mem_addr), 32'h0101);

        // Wait states met but ready low at minimum: ws=3, ready low 2 strobes -> 4 strobes
        mem_data_in = 8'hC3; ready_low = 2;
        launch(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 2'd3);
        run_access;
        check("ws3_rd_cycles", 32'(rd_cyc), 4);
        check("ws3_done_cycle", 32'(done_cyc), 6);
        check("ws3_rdata", 32'(rdata), 32'hC3);
        tick;

        // Timeout on a read with increment: 16 strobe cycles, error data, MAR still increments
        mem_data_in = 8'h42; ready_low = 100;
        launch(1'b0, 16'h0000, 1'b0, 1'b1, 8'h00, 2'd0);
        run_access;
        check("to_rd_cycles", 32'(rd_cyc), 16);
        check("to_done_cycle", 32'(done_cyc), 18);
        check("to_bus_error", 32'(err_at_done), 1);
        check("to_rdata", 32'(rdata), 32'hFF);
        tick;
        check("to_error_pulse", 32'(bus_error), 0);
        check("to_mar_inc", 32'(mem_addr), 32'h0102);

        // Address wrap
        mem_data_in = 8'h5A; ready_low = 0;
        launch(1'b1, 16'hFFFF, 1'b0, 1'b1, 8'h00, 2'd0);
        run_access;
        check("wrap_addr_during", 32'(mem_addr), 32'hFFFF);
        tick;
        check("wrap_mar", 32'(mem_addr), 32'h0000);
        check("wrap_rdata", 32'(rdata), 32'h5A);

        // Ignored inputs while busy
        mem_data_in = 8'h77; ready_low = 0; toggle_busy = 1'b1;
        launch(1'b1, 16'h4000, 1'b0, 1'b0, 8'h00, 2'd0);
        run_access;
        toggle_busy = 1'b0;
        check("ign_done_cycle", 32'(done_cyc), 3);
        check("ign_rdata", 32'(rdata), 32'h77);
        tick;
        check("ign_mar", 32'(mem_addr), 32'h4000);
        idle_done = 0; idle_busy = 0;
        for (int i = 0; i < 4; i++) begin
            idle_done += int'(done);
            idle_busy += int'(busy);
            tick;
        end
        check("ign_no_extra_done", 32'(idle_done), 0);
        check("ign_no_extra_busy", 32'(idle_busy), 0);

        // Reset mid-STROBE of a write
        ready_low = 100; mem_ready = 1'b0;
        launch(1'b1, 16'h00F0, 1'b1, 1'b1, 8'h99, 2'd0);
        tick;
        tick;
        check("rst_mid_wr_high", 32'(mem_wr), 1);
        check("rst_mid_oe_high", 32'(mem_data_oe), 1);
        reset = 1'b0;
        #1;
        check("rst_mid_wr", 32'(mem_wr), 0);
        check("rst_mid_oe", 32'(mem_data_oe), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_mar", 32'(mem_addr), 0);
        check("rst_mid_data_out", 32'(mem_data_out), 0);
        tick;
        check("rst_mid_no_done", 32'(done), 0);
        reset = 1'b1;
        tick;
        check("rst_after_busy", 32'(busy), 0);
        check("rst_after_mar", 32'(mem_addr), 0);

        // Operation resumes after reset
        mem_data_in = 8'h3E; ready_low = 0;
        launch(1'b1, 16'h2222, 1'b0, 1'b0, 8'h00, 2'd1);
        run_access;
        check("post_rst_done_cycle", 32'(done_cyc), 4);
        check("post_rst_rdata", 32'(rdata), 32'h3E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu6_bus_interface.md
CPU6_BUS_INTERFACE -- requirements
Module: cpu6_bus_interface

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum STROBE cycles before an access is aborted.
REQ-002 SHALL have ports:
- clock  input  1  sole clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low.
- req  input  1  access request from CPU; sampled only in IDLE.
- we  input  1  1 = write, 0 = read; sampled with req.
- addr_load  input  1  load the memory address register (MAR) from addr_in.
- addr_in  input  16  new MAR value.
- addr_inc  input  1  post-increment MAR when the access ends; sampled with req.
- wdata  input  8  write data; sampled with req.
- wait_states  input  2  minimum extra STROBE cycles (0-3); sampled with req.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- bus_error  output  1  one-cycle pulse, coincident with done, on timeout.
- rdata  output  8  registered read data.
- mem_addr  output  16  external address; always equals MAR.
- mem_data_out  output  8  write data to the external bus.
- mem_data_oe  output  1  external data-bus drive enable.
- mem_data_in  input  8  read data from the external bus.
- mem_rd  output  1  read strobe.
- mem_wr  output  1  write strobe.
- mem_ready  input  1  device ready; low extends STROBE.

Function
REQ-003 SHALL implement a four-state FSM: IDLE, SETUP, STROBE, HOLD.
REQ-004 IDLE with req=1 at an edge: latch we, addr_inc, wdata (into mem_data_out) and wait_states; next state SETUP.
REQ-005 addr_load SHALL be honoured only in IDLE; if addr_load and req are high on the same edge, the access SHALL use the newly loaded address.
REQ-006 req, addr_load and all latched inputs SHALL be ignored outside IDLE; no queuing.
REQ-007 SETUP SHALL last exactly one cycle, with address valid and no strobe; next state STROBE.
REQ-008 STROBE timing:
- mem_rd (read) or mem_wr (write) SHALL be high for every STROBE cycle only.
- STROBE SHALL last at least wait_states+1 cycles.
- STROBE SHALL exit on the first edge at which that minimum is met and mem_ready=1.
REQ-009 On a normal read exit, rdata SHALL capture mem_data_in at that edge; rdata SHALL otherwise hold its value.
REQ-010 If STROBE reaches TIMEOUT_CYCLES cycles without exit: go to HOLD, assert bus_error with done, and load rdata with 8'hFF (reads only).
REQ-011 HOLD SHALL last one cycle: strobes low, done=1; next state IDLE.
REQ-012 mem_data_oe SHALL be high in SETUP, STROBE and HOLD for writes only; it SHALL be low for reads and in IDLE.
REQ-013 On the HOLD->IDLE edge, if the latched addr_inc=1, MAR SHALL increment modulo 2^16 (16'hFFFF -> 16'h0000); this applies to errored accesses too.
REQ-014 Latency with wait_states=0 and ready high: req sampled at edge k; SETUP in cycle k+1, STROBE in cycle k+2, done in cycle k+3. A new req may be accepted at edge k+4 (earliest).
REQ-015 mem_rd and mem_wr SHALL never be high simultaneously; outputs SHALL be registered or decoded from state only (no input-to-output combinational path).

Reset
REQ-016 reset low SHALL immediately force:
- state IDLE
- MAR = 16'h0000
- rdata = 8'h00
- mem_data_out = 8'h00
- busy, done, bus_error, mem_rd, mem_wr, mem_data_oe = 0
- wait and timeout counters cleared.
REQ-017 Reset during any access SHALL abort it with no done pulse and no MAR increment; operation resumes on the first edge after reset deasserts.

Structure
REQ-018 State encodings, the default timeout value and the rdata error value 8'hFF SHALL live in a shared CPU6 bus definitions header, included by this block and the CPU6 top level.
REQ-019 The block SHALL be a single flat module; the wait/timeout counter is inline, with no sub-module.

Verification
REQ-020 Read, zero wait: addr_load 16'h1234 with req, we=0, mem_data_in=8'hA5, ready=1 -> mem_rd high for one cycle; done at k+3; rdata=8'hA5; MAR stays 16'h1234.
REQ-021 Write, wait_states=2, ready low for 4 STROBE cycles: wdata=8'h3C -> mem_wr high for 5 cycles; mem_data_oe high SETUP..HOLD; mem_data_out=8'h3C; done at k+7.
REQ-022 Wrap: MAR=16'hFFFF, addr_inc=1, read -> MAR=16'h0000 after done.
REQ-023 Timeout: ready held low, read -> STROBE lasts exactly 16 cycles; done and bus_error pulse together; rdata=8'hFF.
REQ-024 Reset mid-STROBE of a write -> mem_wr, mem_data_oe and busy drop immediately; no done; MAR=16'h0000.
REQ-025 Ignored inputs: req and addr_load toggled while busy -> no extra access; MAR unchanged; exactly one done.
